// File: rtl/dram_addr_composer.sv
// dram_addr_composer
// Burst address generator for the DRAM-to-L2 return path. Commands arrive as
// separate offset/bank/row/column fields plus a burst length. They wait in a
// small command FIFO and are replayed as one packed L2 address per beat, laid
// out as {offset, bank_id, row_id, col_id}. Within a burst the column wraps
// inside its row and never carries into row, bank or offset.
module dram_addr_composer #(
  parameter int ADDR_WIDTH   = 20,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]   cmd_offset,
  input  logic [$clog2(NUM_OF_BANKS)-1:0]  cmd_bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]   cmd_row_id,
  input  logic [$clog2(NUM_OF_COLS)-1:0]   cmd_col_id,
  input  logic [$clog2(NUM_OF_COLS):0]     cmd_burst_len,
  output logic                             addr_valid,
  input  logic                             addr_ready,
  output logic [ADDR_WIDTH-1:0]            addr,
  output logic                             addr_last,
  output logic                             busy
);

  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);
  localparam int CW = $clog2(NUM_OF_COLS);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Bit positions of each field inside a stored FIFO entry.
  localparam int LEN_LSB  = 0;
  localparam int COL_LSB  = LEN_LSB + CW + 1;
  localparam int ROW_LSB  = COL_LSB + CW;
  localparam int BANK_LSB = ROW_LSB + RW;
  localparam int OFF_LSB  = BANK_LSB + BW;
  localparam int EW       = OFF_LSB + RW;

  localparam logic [CW:0]   LEN_MAX  = (CW+1)'(NUM_OF_COLS);
  localparam logic [CW:0]   LEN_ONE  = (CW+1)'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_OF_COLS - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [CW:0]   len_norm;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  logic [RW-1:0] head_offset;
  logic [BW-1:0] head_bank;
  logic [RW-1:0] head_row;
  logic [CW-1:0] head_col;
  logic [CW:0]   head_len;

  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);

  // Ready is a function of registered occupancy only, so a same-cycle pop
  // never opens the door for an extra push.
  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;

  // Oversized bursts are clamped to one full row; zero length is kept so the
  // entry can be discarded cleanly when it reaches the head.
  assign len_norm = (cmd_burst_len > LEN_MAX) ? LEN_MAX : cmd_burst_len;
  assign wr_entry = {cmd_offset, cmd_bank_id, cmd_row_id, cmd_col_id, len_norm};

  // Write the incoming command into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // The head is read asynchronously so IDLE can pop and load in one edge.
  assign head        = fifo_mem[rd_ptr_reg];
  assign head_offset = head[OFF_LSB  +: RW];
  assign head_bank   = head[BANK_LSB +: BW];
  assign head_row    = head[ROW_LSB  +: RW];
  assign head_col    = head[COL_LSB  +: CW];
  assign head_len    = head[LEN_LSB  +: CW+1];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the
  // count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg,     state_next;
  logic [RW-1:0] offset_reg,    offset_next;
  logic [BW-1:0] bank_reg,      bank_next;
  logic [RW-1:0] row_reg,       row_next;
  logic [CW-1:0] col_reg,       col_next;
  logic [CW:0]   remaining_reg, remaining_next;
  logic          valid_reg,     valid_next;
  logic          last_reg,      last_next;

  // Next-state, pop decision and field updates for the beat generator.
  always_comb begin
    state_next     = state_reg;
    offset_next    = offset_reg;
    bank_next      = bank_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    remaining_next = remaining_reg;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_len != '0) begin
            offset_next    = head_offset;
            bank_next      = head_bank;
            row_next       = head_row;
            col_next       = head_col;
            remaining_next = head_len;
            state_next     = BURST;
          end
        end
      end

      BURST: begin
        if (addr_ready) begin
          if (remaining_reg == LEN_ONE) begin
            // Final beat: chain straight into the next command when one is
            // waiting so the stream has no bubble at the boundary.
            if (!fifo_empty) begin
              pop = 1'b1;
              if (head_len != '0) begin
                offset_next    = head_offset;
                bank_next      = head_bank;
                row_next       = head_row;
                col_next       = head_col;
                remaining_next = head_len;
              end else begin
                state_next = IDLE;
              end
            end else begin
              state_next = IDLE;
            end
          end else begin
            col_next       = (col_reg == COL_LAST) ? '0 : col_reg + 1'b1;
            remaining_next = remaining_reg - 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Stream outputs are precomputed here so they leave the block as flops.
    valid_next = (state_next == BURST);
    last_next  = (state_next == BURST) && (remaining_next == LEN_ONE);
  end

  // State and beat registers; reset drops any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      offset_reg    <= '0;
      bank_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      remaining_reg <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      offset_reg    <= offset_next;
      bank_reg      <= bank_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      remaining_reg <= remaining_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
    end
  end

  assign addr_valid = valid_reg;
  assign addr_last  = last_reg;
  assign addr       = {offset_reg, bank_reg, row_reg, col_reg};
  assign busy       = !fifo_empty || (state_reg == BURST);

endmodule

// File: tb/tb_dram_addr_composer.sv
// Self-checking bench for dram_addr_composer. A reference model turns each
// accepted command into its list of expected beats (plain arithmetic on the
// field values); a monitor pops and compares whenever a beat is presented.
module tb_dram_addr_composer;

  localparam int ADDR_WIDTH   = 20;
  localparam int NUM_OF_BANKS = 8;
  localparam int NUM_OF_ROWS  = 128;
  localparam int NUM_OF_COLS  = 8;
  localparam int FIFO_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_offset = '0;
  logic [2:0]  cmd_bank_id = '0;
  logic [6:0]  cmd_row_id = '0;
  logic [2:0]  cmd_col_id = '0;
  logic [3:0]  cmd_burst_len = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [19:0] addr;
  logic        addr_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int ready_mode = 0;  // 0 = hold low, 1 = hold high, 2 = random

  logic [ADDR_WIDTH-1:0] exp_addr_q[$];
  logic                  exp_last_q[$];

  dram_addr_composer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_OF_BANKS(NUM_OF_BANKS),
    .NUM_OF_ROWS (NUM_OF_ROWS),
    .NUM_OF_COLS (NUM_OF_COLS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_offset   (cmd_offset),
    .cmd_bank_id  (cmd_bank_id),
    .cmd_row_id   (cmd_row_id),
    .cmd_col_id   (cmd_col_id),
    .cmd_burst_len(cmd_burst_len),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a command expands into min(len, NUM_OF_COLS) beats whose
  // column walks forward modulo the row width; other fields stay fixed.
  function automatic void model_push(input int off, input int bank, input int row,
                                     input int col, input int len);
    int n;
    int c;
    int a;
    n = (len > NUM_OF_COLS) ? NUM_OF_COLS : len;
    for (int i = 0; i < n; i++) begin
      c = (col + i) % NUM_OF_COLS;
      a = off * (NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS)
        + bank * (NUM_OF_ROWS * NUM_OF_COLS)
        + row * NUM_OF_COLS + c;
      exp_addr_q.push_back(ADDR_WIDTH'(a));
      exp_last_q.push_back(i == n - 1);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented beat against the scoreboard head and
  // records accepted commands into the model.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr_q.delete();
        exp_last_q.delete();
      end else begin
        if (addr_valid) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got addr 0x%05h, expected no beat", addr);
          end else begin
            if (addr !== exp_addr_q[0] || addr_last !== exp_last_q[0]) begin
              errors++;
              $display("FAIL beat: got addr 0x%05h last %0b, expected addr 0x%05h last %0b",
                       addr, addr_last, exp_addr_q[0], exp_last_q[0]);
            end
            if (addr_ready) begin
              void'(exp_addr_q.pop_front());
              void'(exp_last_q.pop_front());
              beats_seen++;
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          model_push(int'(cmd_offset), int'(cmd_bank_id), int'(cmd_row_id),
                     int'(cmd_col_id), int'(cmd_burst_len));
        end
      end
    end
  endtask

  // Drives addr_ready according to ready_mode, slightly after each edge.
  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       addr_ready = 1'b0;
        1:       addr_ready = 1'b1;
        default: addr_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
  endtask

  // Presents one command and holds it until accepted (bounded wait).
  task automatic push_cmd(input int off, input int bank, input int row,
                          input int col, input int len);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    cmd_offset    = 7'(off);
    cmd_bank_id   = 3'(bank);
    cmd_row_id    = 7'(row);
    cmd_col_id    = 3'(col);
    cmd_burst_len = 4'(len);
    cmd_valid     = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no accept, expected cmd_ready within 300 cycles");
    end
  endtask

  // Waits until every expected beat has been seen and the block is idle.
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int n0;
    bit seen;
    fork
      monitor_loop();
      ready_driver();
    join_none

    // Reset values while rst is held high.
    repeat (3) @(negedge clk);
    chk("rst_addr_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_addr_last", 32'(addr_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single burst with latency check.
    ready_mode = 1;
    push_cmd(5, 3, 'h11, 0, 4);
    @(negedge clk);
    chk("latency_not_yet", 32'(addr_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(addr_valid), 32'd1);
    chk("first_addr", 32'(addr), 32'h0AC88);
    drain("drain_single");

    // Column wrap inside the row.
    push_cmd(0, 7, 'h7F, 6, 4);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_first_addr", 32'(addr), 32'h01FFE);
    drain("drain_wrap");

    // Back-pressure then back-to-back beats across a command boundary.
    ready_mode = 0;
    push_cmd(1, 2, 3, 5, 2);
    push_cmd(4, 5, 6, 7, 2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid_%0d", i), 32'(addr_valid), 32'd1);
    end
    drain("drain_b2b");

    // FIFO full with the sink stalled.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      push_cmd($urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
               $urandom_range(0, 7), 2);
    end
    @(negedge clk);
    chk("full_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("full_cmd_ready_back", 32'(seen), 32'd1);
    drain("drain_full");

    // Zero length: no beats, busy clears.
    push_cmd(9, 1, 2, 3, 0);
    repeat (3) @(negedge clk);
    chk("len0_busy", 32'(busy), 32'd0);

    // Length 15 is clamped to a full row.
    n0 = beats_seen;
    push_cmd(3, 4, 5, 2, 15);
    drain("drain_len15");
    chk("len15_beats", 32'(beats_seen - n0), 32'd8);

    // Reset during the second beat of a long burst.
    push_cmd(2, 1, 9, 3, 8);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (addr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_started", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(addr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    push_cmd(6, 6, 'h40, 1, 3);
    drain("drain_after_rst");

    // Randomised traffic with a random sink.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_cmd($urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
               $urandom_range(0, 7), $urandom_range(0, 15));
    end
    drain("drain_random");
    chk("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
